even_parity_serial_checker: RTL and testbench

- Serial receiver and even-parity checker for the lab parity link.
- Frame format: idle-high line, start bit (0), DATA_BITS data bits LSB first, one even-parity bit, stop bit (1).
- Samples each bit at mid-bit, deserializes the data and presents it with parity and framing error flags.
- Sits at the receive end of the link; the transmit end computes parity as the XOR of all data bits.

---
 rtl/even_parity_serial_checker_pkg.sv | 22 ++
 rtl/even_parity_serial_checker_bit_sync.sv | 34 +++
 rtl/even_parity_serial_checker.sv | 136 +++++++++++++
 tb/tb_even_parity_serial_checker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/even_parity_serial_checker_pkg.sv
// Shared constants for the lab parity link: receiver state encoding, frame
// line levels and the parity rule used by both ends of the link.
package even_parity_serial_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity over up to 16 data bits; unused upper bits must be zero.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/even_parity_serial_checker_bit_sync.sv
// Two-flop synchronizer for an asynchronous line; both flops reset to RST_VAL
// so an idle-high line produces no edge when reset is released.
module bit_sync
  import even_parity_serial_checker_pkg::*;
#(
  parameter logic RST_VAL = IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/even_parity_serial_checker.sv
// Serial receiver with even-parity and stop-bit checking. Bits are sampled at
// mid-bit; results are registered and presented with a one-cycle data_valid.
module even_parity_serial_checker
  import even_parity_serial_checker_pkg::*;
#(
  parameter int DATA_BITS    = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int H  = CLKS_PER_BIT / 2;

  logic s;

  bit_sync #(.RST_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (s)
  );

  rx_state_e            state_q, state_d;
  logic                 prev_s_q, prev_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  logic mid_start, mid_bit;
  assign mid_start = (cnt_q == CW'(H - 1));
  assign mid_bit   = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d      = state_q;
    prev_s_d     = s;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Only a true falling edge starts a frame; a line stuck low is ignored.
        if (prev_s_q == IDLE_LEVEL && s == START_BIT) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (mid_start) begin
          cnt_d   = '0;
          state_d = (s == START_BIT) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (mid_bit) begin
          cnt_d   = '0;
          shift_d = (shift_q >> 1) | (DATA_BITS'(s) << (DATA_BITS - 1));
          bit_d   = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (mid_bit) begin
          cnt_d   = '0;
          par_d   = s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave mid-stop-bit so a start bit right after the stop bit is caught.
        if (mid_bit) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          data_valid_d = 1'b1;
          data_out_d   = shift_q;
          parity_err_d = even_parity(16'(shift_q)) ^ par_q;
          frame_err_d  = (s != STOP_BIT);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_s_q     <= IDLE_LEVEL;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_s_q     <= prev_s_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_even_parity_serial_checker.sv
// Directed and randomized frames against a frame-level model of the receiver.
module tb_even_parity_serial_checker;

  localparam int DB  = 4;
  localparam int C   = 16;
  localparam int LAT = 2 + C / 2 + (DB + 2) * C + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic [DB-1:0] data_out;
  logic          data_valid, parity_err, frame_err, busy;

  even_parity_serial_checker #(.DATA_BITS(DB), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [DB-1:0] data;
    logic        pe, fe;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [DB-1:0] data;
    logic        pe, fe, busy_now, busy_prev;
  } rx_t;

  exp_t expq[$];
  rx_t  rxq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic busy_d1 = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (data_valid)
      rxq.push_back('{cyc, data_out, parity_err, frame_err, busy, busy_d1});
    busy_d1 = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (C) tick();
  endtask

  // Model: parity error means an odd count of ones over data and parity bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop);
    expq.push_back('{cyc, d, logic'(($countones(d) + int'(p)) % 2), ~stop});
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_count"}, rxq.size(), expq.size());
    n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"},    rxq[i].data, expq[i].data);
      chk({tag, "_pe"},      rxq[i].pe,   expq[i].pe);
      chk({tag, "_fe"},      rxq[i].fe,   expq[i].fe);
      chk({tag, "_latency"}, rxq[i].cyc - expq[i].cyc, LAT);
      chk({tag, "_busy_dv"}, rxq[i].busy_now, 1'b0);
      chk({tag, "_busy_pre"}, rxq[i].busy_prev, 1'b1);
    end
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    int k;
    logic [DB-1:0] rd;
    logic rp, rs;

    serial_in = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_data", data_out, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_pe", parity_err, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_busy", busy, 0);
    repeat (100) tick();
    chk("idle_no_dv", rxq.size(), 0);
    chk("idle_busy", busy, 0);

    send_frame(4'hB, 1'b1, 1'b1);
    idle(10);
    compare("good");
    chk("hold_data", data_out, 4'hB);

    send_frame(4'h5, 1'b1, 1'b1);
    idle(10);
    send_frame(4'h3, 1'b0, 1'b1);
    idle(10);
    compare("parity");

    send_frame(4'h3, 1'b0, 1'b0);
    serial_in = 1'b0;
    repeat (40) tick();
    chk("break_busy", busy, 0);
    idle(16);
    send_frame(4'hA, 1'b0, 1'b1);
    idle(10);
    compare("break");

    k = cyc;
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    tick();
    chk("glitch_busy_hi", busy, 1);
    repeat (11 - (cyc - k)) tick();
    chk("glitch_busy_lo", busy, 0);
    idle(10);
    chk("glitch_no_dv", rxq.size(), 0);

    send_frame(4'h6, 1'b0, 1'b1);
    send_frame(4'h9, 1'b0, 1'b1);
    idle(10);
    if (rxq.size() >= 2)
      chk("b2b_spacing", rxq[1].cyc - rxq[0].cyc, (DB + 3) * C);
    compare("b2b");

    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    serial_in = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_data", data_out, 0);
    chk("mrst_dv", data_valid, 0);
    chk("mrst_pe", parity_err, 0);
    chk("mrst_fe", frame_err, 0);
    chk("mrst_busy", busy, 0);
    idle(150);
    chk("mrst_no_dv", rxq.size(), 0);
    send_frame(4'hC, 1'b0, 1'b1);
    idle(10);
    compare("mrst");

    for (int i = 0; i < 10; i++) begin
      rd = DB'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? ~(^rd) : ^rd;
      rs = ($urandom_range(0, 9) != 0);
      send_frame(rd, rp, rs);
      idle(rs ? $urandom_range(0, 20) : $urandom_range(2, 20));
    end
    idle(10);
    compare("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
